fl_fifo_sf: RTL and testbench

FL_FIFO_SF -- requirements
Module: fl_fifo_sf

---
 rtl/fl_fifo_sf.sv | 113 +++++++++++
 tb/tb_fl_fifo_sf.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fl_fifo_sf.sv
// fl_fifo_sf: FrameLink FIFO, first-word-fall-through, optional store-and-forward frame release
//   clk, reset (async, active-high)
//   rx_*  : write side (data, rem, active-low delimiters, src_rdy_n in / dst_rdy_n out)
//   tx_*  : read side  (data, rem, active-low delimiters, src_rdy_n out / dst_rdy_n in)
//   lstblk, status, empty, full, frame_rdy : registered occupancy / frame flags
module fl_fifo_sf #(
  parameter int DATA_WIDTH        = 64,
  parameter int DREM_WIDTH        = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1,
  parameter int ITEMS             = 1024,
  parameter int BLOCK_SIZE        = 16,
  parameter int STATUS_WIDTH      = 7,
  parameter bit USE_BRAMS         = 1'b1,
  parameter bit STORE_AND_FORWARD = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic [DREM_WIDTH-1:0]   rx_rem,
  input  logic                    rx_sof_n,
  input  logic                    rx_sop_n,
  input  logic                    rx_eop_n,
  input  logic                    rx_eof_n,
  input  logic                    rx_src_rdy_n,
  output logic                    rx_dst_rdy_n,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic [DREM_WIDTH-1:0]   tx_rem,
  output logic                    tx_sof_n,
  output logic                    tx_sop_n,
  output logic                    tx_eop_n,
  output logic                    tx_eof_n,
  output logic                    tx_src_rdy_n,
  input  logic                    tx_dst_rdy_n,
  output logic                    lstblk,
  output logic [STATUS_WIDTH-1:0] status,
  output logic                    empty,
  output logic                    full,
  output logic                    frame_rdy
);
  localparam int AW = $clog2(ITEMS);
  localparam int CW = AW + 1;
  localparam int W = DATA_WIDTH + DREM_WIDTH + 4;
  localparam logic [CW-1:0] FULL_CNT = CW'(ITEMS);
  localparam logic [CW-1:0] LST_CNT = CW'(ITEMS - BLOCK_SIZE);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_nx, frames, frames_nx;
  logic [W-1:0] wr_word, pipe_q, out_q;
  logic pipe_vld, out_vld, force_rel, full_r;
  logic wr, rd, pipe_ld, out_ld, release_ok, fr_inc, fr_dec;
  // word layout: {data, rem, sof_n, sop_n, eop_n, eof_n}; bit 3 = sof_n, bit 0 = eof_n
  assign wr_word = {rx_data, rx_rem, rx_sof_n, rx_sop_n, rx_eop_n, rx_eof_n};
  assign {tx_data, tx_rem, tx_sof_n, tx_sop_n, tx_eop_n, tx_eof_n} = out_q;
  assign rx_dst_rdy_n = full_r;
  assign full = full_r;
  assign wr = !rx_src_rdy_n && !full_r;
  // only a frame start is held back; the rest of a released frame streams freely
  assign release_ok = !STORE_AND_FORWARD || out_q[3] || (frames != '0) || force_rel;
  assign tx_src_rdy_n = !(out_vld && release_ok);
  assign rd = !tx_src_rdy_n && !tx_dst_rdy_n;
  // prefetch chain: memory -> pipe_q (RAM read register) -> out_q (output register)
  assign out_ld = pipe_vld && (!out_vld || rd);
  assign pipe_ld = (cnt != (CW'(pipe_vld) + CW'(out_vld))) && (!pipe_vld || out_ld);
  assign fr_inc = wr && !rx_eof_n;
  assign fr_dec = rd && !out_q[0];
  always_comb begin
    cnt_nx = (wr && !rd) ? cnt + 1'b1 : (rd && !wr) ? cnt - 1'b1 : cnt;
    frames_nx = (fr_inc && !fr_dec) ? frames + 1'b1 : (fr_dec && !fr_inc) ? frames - 1'b1 : frames;
  end
  if (USE_BRAMS) begin : g_bram
    (* ram_style = "block" *) logic [W-1:0] mem [ITEMS];
    always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= wr_word;
      if (pipe_ld) pipe_q <= mem[rd_ptr];
    end
  end else begin : g_dram
    (* ram_style = "distributed" *) logic [W-1:0] mem [ITEMS];
    always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= wr_word;
      if (pipe_ld) pipe_q <= mem[rd_ptr];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      frames <= '0;
      pipe_vld <= 1'b0;
      out_vld <= 1'b0;
      out_q <= '1;
      force_rel <= 1'b0;
      full_r <= 1'b0;
      empty <= 1'b1;
      lstblk <= 1'b0;
      status <= '0;
      frame_rdy <= 1'b0;
    end else begin
      wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pipe_ld ? rd_ptr + 1'b1 : rd_ptr;
      cnt <= cnt_nx;
      frames <= frames_nx;
      pipe_vld <= pipe_ld || (pipe_vld && !out_ld);
      out_vld <= out_ld || (out_vld && !rd);
      out_q <= out_ld ? pipe_q : out_q;
      // a full FIFO with no complete frame can only drain by releasing the partial frame
      force_rel <= fr_dec ? 1'b0 : (full_r && frames == '0) ? 1'b1 : force_rel;
      full_r <= cnt_nx == FULL_CNT;
      empty <= cnt_nx == '0;
      lstblk <= cnt_nx >= LST_CNT;
      status <= cnt_nx[CW-1 -: STATUS_WIDTH];
      frame_rdy <= frames_nx != '0;
    end
  end
endmodule

// File: tb/tb_fl_fifo_sf.sv
// tb_fl_fifo_sf: cut-through and store-and-forward instances driven through one shared stimulus path
module tb_fl_fifo_sf;
  localparam int DW = 64;
  localparam int RW = 3;
  localparam int N = 16;
  localparam int SW = 3;
  localparam int W = DW + RW + 4;
  typedef struct packed {
    logic src, hold, emp, ful, lst, drdy_n, srdy_n, frdy;
    logic [SW-1:0] st;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic [RW-1:0] rx_rem = '0;
  logic rx_sof_n = 1'b1, rx_sop_n = 1'b1, rx_eop_n = 1'b1, rx_eof_n = 1'b1;
  logic rx_src_rdy_n = 1'b1;
  logic tx_hold = 1'b1, tx_rnd = 1'b0, rnd_bit = 1'b1;
  logic tx_dst_rdy_n;
  logic [DW-1:0] o_data [2];
  logic [RW-1:0] o_rem [2];
  logic [SW-1:0] o_stat [2];
  logic o_sof [2], o_sop [2], o_eop [2], o_eof [2], o_srdy [2], o_drdy [2];
  logic o_lst [2], o_emp [2], o_full [2], o_frdy [2];
  logic [DW-1:0] tx_data;
  logic [RW-1:0] tx_rem;
  logic [SW-1:0] status;
  logic tx_sof_n, tx_sop_n, tx_eop_n, tx_eof_n, tx_src_rdy_n, rx_dst_rdy_n;
  logic lstblk, empty, full, frame_rdy;
  logic [W-1:0] tx_word, rx_word;
  logic [W-1:0] sb [$];
  int tests = 0, fails = 0, n_rd = 0, last_wait = 0;
  logic saw_force = 1'b0;
  vec_t tbl [33];
  always #5 clk = ~clk;
  assign tx_dst_rdy_n = tx_rnd ? rnd_bit : tx_hold;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    fl_fifo_sf #(
      .DATA_WIDTH(DW), .DREM_WIDTH(RW), .ITEMS(N), .BLOCK_SIZE(4), .STATUS_WIDTH(SW),
      .USE_BRAMS(g == 0), .STORE_AND_FORWARD(g == 1)
    ) u_dut (
      .clk(clk), .reset(rst),
      .rx_data(rx_data), .rx_rem(rx_rem),
      .rx_sof_n(rx_sof_n), .rx_sop_n(rx_sop_n), .rx_eop_n(rx_eop_n), .rx_eof_n(rx_eof_n),
      .rx_src_rdy_n(rx_src_rdy_n | (sel != 1'(g))), .rx_dst_rdy_n(o_drdy[g]),
      .tx_data(o_data[g]), .tx_rem(o_rem[g]),
      .tx_sof_n(o_sof[g]), .tx_sop_n(o_sop[g]), .tx_eop_n(o_eop[g]), .tx_eof_n(o_eof[g]),
      .tx_src_rdy_n(o_srdy[g]), .tx_dst_rdy_n(tx_dst_rdy_n | (sel != 1'(g))),
      .lstblk(o_lst[g]), .status(o_stat[g]), .empty(o_emp[g]), .full(o_full[g]), .frame_rdy(o_frdy[g])
    );
  end
  assign tx_data = o_data[sel];
  assign tx_rem = o_rem[sel];
  assign tx_sof_n = o_sof[sel];
  assign tx_sop_n = o_sop[sel];
  assign tx_eop_n = o_eop[sel];
  assign tx_eof_n = o_eof[sel];
  assign tx_src_rdy_n = o_srdy[sel];
  assign rx_dst_rdy_n = o_drdy[sel];
  assign lstblk = o_lst[sel];
  assign status = o_stat[sel];
  assign empty = o_emp[sel];
  assign full = o_full[sel];
  assign frame_rdy = o_frdy[sel];
  assign tx_word = {tx_data, tx_rem, tx_sof_n, tx_sop_n, tx_eop_n, tx_eof_n};
  assign rx_word = {rx_data, rx_rem, rx_sof_n, rx_sop_n, rx_eop_n, rx_eof_n};
  initial forever begin
    @(posedge clk);
    #1;
    rnd_bit = $urandom_range(0, 3) == 0;
  end
  // scoreboard: a handshake seen before an edge is the transfer that edge performs
  initial forever begin
    logic [W-1:0] exp;
    @(negedge clk);
    if (rst) sb.delete();
    else begin
      tests++;
      if (empty !== (sb.size() == 0) || full !== (sb.size() == N)) begin
        fails++;
        $display("FAIL occupancy: empty=%b full=%b, required empty=%b full=%b for %0d stored words",
                 empty, full, sb.size() == 0, sb.size() == N, sb.size());
      end
      if (full && !frame_rdy) saw_force = 1'b1;
      if (!tx_src_rdy_n && !tx_dst_rdy_n) begin
        tests++;
        n_rd++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL tx_underflow: got word %0h with nothing expected", tx_word);
        end else begin
          exp = sb.pop_front();
          if (tx_word !== exp) begin
            fails++;
            $display("FAIL tx_word: got %0h, required %0h", tx_word, exp);
          end
        end
      end
      if (!rx_src_rdy_n && !rx_dst_rdy_n) sb.push_back(rx_word);
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset(input logic s);
    rst = 1'b1;
    sel = s;
    rx_src_rdy_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        {rx_dst_rdy_n, tx_src_rdy_n, tx_sof_n, tx_sop_n, tx_eop_n, tx_eof_n, empty, full, lstblk, status, frame_rdy},
        {1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0});
    rst = 1'b0;
  endtask
  task automatic put(input logic [DW-1:0] d, input logic [RW-1:0] r, input logic sof_n, input logic eof_n);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    rx_data = d;
    rx_rem = r;
    rx_sof_n = sof_n;
    rx_sop_n = sof_n;
    rx_eop_n = eof_n;
    rx_eof_n = eof_n;
    rx_src_rdy_n = 1'b0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = !rx_dst_rdy_n;
      @(posedge clk);
      #1;
      n++;
    end
    rx_src_rdy_n = 1'b1;
    last_wait = n - 1;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL put_timeout: word %0h not accepted, required acceptance within 300 cycles", d);
    end
  endtask
  task automatic drain(input string nm, input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 128'(sb.size()), 128'd0);
  endtask
  task automatic rand_frames(input int nf);
    for (int f = 0; f < nf; f++) begin
      int bytes, nw;
      bytes = $urandom_range(1, 36);
      nw = (bytes + 7) / 8;
      for (int w = 0; w < nw; w++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        put({$urandom, $urandom}, (w == nw - 1) ? RW'((bytes - 1) % 8) : 3'd7, w != 0, w != nw - 1);
      end
    end
  endtask
  initial begin
    int n;
    for (int i = 0; i < 33; i++) begin
      int occ;
      occ = (i < 16) ? i + 1 : (i == 16) ? 16 : 32 - i;
      tbl[i].src = i < 17;
      tbl[i].hold = i < 17;
      tbl[i].emp = occ == 0;
      tbl[i].ful = occ == N;
      tbl[i].lst = occ >= 12;
      tbl[i].drdy_n = occ == N;
      tbl[i].srdy_n = i < 2 || occ == 0;
      tbl[i].frdy = occ != 0;
      tbl[i].st = SW'(occ >> 2);
    end
    do_reset(1'b0);
    for (int i = 0; i < 33; i++) begin
      rx_data = 64'hC0DE_0000_0000_0000 | 64'(i);
      rx_rem = RW'(i);
      rx_sof_n = 1'b0;
      rx_sop_n = 1'b0;
      rx_eop_n = 1'b0;
      rx_eof_n = 1'b0;
      rx_src_rdy_n = !tbl[i].src;
      tx_hold = tbl[i].hold;
      @(posedge clk);
      #1;
      chk($sformatf("table_row%0d", i),
          {empty, full, lstblk, rx_dst_rdy_n, tx_src_rdy_n, frame_rdy, status},
          {tbl[i].emp, tbl[i].ful, tbl[i].lst, tbl[i].drdy_n, tbl[i].srdy_n, tbl[i].frdy, tbl[i].st});
    end
    rx_src_rdy_n = 1'b1;
    tx_hold = 1'b0;
    put(64'hDEAD_BEEF_0123_4567, 3'd5, 1'b0, 1'b0);
    chk("latency_edge0", tx_src_rdy_n, 1'b1);
    idle(1);
    chk("latency_edge1", tx_src_rdy_n, 1'b1);
    idle(1);
    chk("latency_edge2", {tx_src_rdy_n, tx_data, tx_rem, tx_sof_n, tx_sop_n, tx_eop_n, tx_eof_n},
        {1'b0, 64'hDEAD_BEEF_0123_4567, 3'd5, 4'h0});
    drain("latency_drain", 20);
    do_reset(1'b1);
    tx_hold = 1'b0;
    for (int w = 0; w < 4; w++) begin
      put(64'h5AF0_0000_0000_0000 | 64'(w), 3'd7, w != 0, 1'b1);
      chk($sformatf("saf_hold_w%0d", w), {tx_src_rdy_n, frame_rdy}, {1'b1, 1'b0});
    end
    for (int c = 0; c < 3; c++) begin
      idle(1);
      chk($sformatf("saf_hold_idle%0d", c), {tx_src_rdy_n, frame_rdy}, {1'b1, 1'b0});
    end
    put(64'h5AF0_0000_0000_0004, 3'd2, 1'b1, 1'b0);
    chk("saf_frame_rdy", frame_rdy, 1'b1);
    n = 0;
    while (tx_src_rdy_n && n < 10) begin
      idle(1);
      n++;
    end
    n = 0;
    while (!tx_src_rdy_n && n < 20) begin
      idle(1);
      n++;
    end
    chk("saf_burst_len", 128'(n), 128'd5);
    drain("saf_drain", 20);
    do_reset(1'b1);
    tx_hold = 1'b0;
    saw_force = 1'b0;
    n_rd = 0;
    for (int w = 0; w < 20; w++) put(64'hF0CE_0000_0000_0000 | 64'(w), 3'd7, w != 0, w != 19);
    drain("force_drain", 200);
    chk("force_seen", saw_force, 1'b1);
    chk("force_count", 128'(n_rd), 128'd20);
    do_reset(1'b0);
    tx_rnd = 1'b1;
    rand_frames(1000);
    drain("rand_ct_drain", 3000);
    tx_rnd = 1'b0;
    do_reset(1'b1);
    tx_rnd = 1'b1;
    rand_frames(200);
    drain("rand_saf_drain", 3000);
    tx_rnd = 1'b0;
    do_reset(1'b0);
    tx_hold = 1'b1;
    for (int w = 0; w < 3; w++) put(64'h0BAD_0000_0000_0000 | 64'(w), 3'd7, w != 0, 1'b1);
    rst = 1'b1;
    idle(1);
    chk("midreset_during", {empty, frame_rdy}, {1'b1, 1'b0});
    rst = 1'b0;
    chk("midreset_after", {empty, frame_rdy, rx_dst_rdy_n}, {1'b1, 1'b0, 1'b0});
    put(64'h600D_0000_0000_0001, 3'd3, 1'b0, 1'b0);
    chk("first_write_wait", 128'(last_wait), 128'd0);
    chk("first_write_stored", empty, 1'b0);
    tx_hold = 1'b0;
    n = 0;
    while (tx_src_rdy_n && n < 10) begin
      idle(1);
      n++;
    end
    chk("midreset_first_out", {tx_src_rdy_n, tx_data}, {1'b0, 64'h600D_0000_0000_0001});
    drain("midreset_drain", 20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
